// File: rtl/lsu_bus_adapter_pkg.sv
// Shared types and the access-width alignment helper for the LSU bus adapter.
package lsu_pkg;

  typedef enum logic [2:0] {
    LC_B  = 3'b000,
    LC_H  = 3'b001,
    LC_W  = 3'b010,
    LC_BU = 3'b011,
    LC_HU = 3'b100
  } load_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Only halfword and word widths can be misaligned; byte accesses never are.
  function automatic logic is_misaligned(input logic [2:0] load_ctrl,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (load_ctrl)
      LC_H, LC_HU: mis = addr_lo[0];
      LC_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_bus_adapter_load_aligner.sv
// Right-aligns a byte/halfword lane of a memory word and sign/zero-extends it.
module load_aligner
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_ctrl,
  output logic [31:0] data
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (load_ctrl)
      LC_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LC_BU:   data = {24'h000000, byte_sel};
      LC_H:    data = {{16{half_sel[15]}}, half_sel};
      LC_HU:   data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Load/store bus adapter: one access per instruction, core stalled until the
// valid/ready transfer completes or times out.
module lsu_bus_adapter
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  input  logic [2:0]  req_load_ctrl,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        err_misaligned,
  output logic        err_timeout,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e       state_q, state_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       mask_q, mask_d;
  logic [2:0]       lc_q, lc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic [31:0]      load_data_q, load_data_d;

  logic             misaligned;
  logic             in_bus;
  logic [31:0]      aligned_data;

  load_aligner u_aligner (
    .rdata     (bus_rdata),
    .offset    (addr_q[1:0]),
    .load_ctrl (lc_q),
    .data      (aligned_data)
  );

  assign misaligned = is_misaligned(req_load_ctrl, req_addr[1:0]);
  assign in_bus     = (state_q == BUS);

  // Bus side is driven only while a transfer is outstanding.
  assign bus_valid = in_bus;
  assign bus_we    = in_bus & we_q;
  assign bus_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_wdata = in_bus ? wdata_q : 32'h0;
  assign bus_be    = (in_bus & we_q) ? mask_q : 4'b0000;
  assign load_data = load_data_q;

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    mask_d         = mask_q;
    lc_d           = lc_q;
    cnt_d          = cnt_q;
    to_d           = to_q;
    load_data_d    = load_data_q;
    stall          = 1'b0;
    load_valid     = 1'b0;
    err_misaligned = 1'b0;
    err_timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            err_misaligned = 1'b1;
          end else begin
            stall   = 1'b1;
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            mask_d  = req_mask;
            lc_d    = req_load_ctrl;
            cnt_d   = '0;
            to_d    = 1'b0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        stall = 1'b1;
        if (bus_ready) begin
          if (!we_q) load_data_d = aligned_data;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          to_d        = 1'b1;
          load_data_d = 32'h0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        load_valid  = ~we_q;
        err_timeout = to_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      mask_q      <= 4'b0000;
      lc_q        <= 3'b000;
      cnt_q       <= '0;
      to_q        <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      lc_q        <= lc_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      load_data_q <= load_data_d;
    end
  end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Self-checking bench for lsu_bus_adapter: directed scenarios plus randomized
// accesses compared against an arithmetic model of the access rules.
module tb_lsu_bus_adapter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_mask;
  logic [2:0]  req_load_ctrl;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid, err_misaligned, err_timeout;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  lsu_bus_adapter #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_mask       (req_mask),
    .req_load_ctrl  (req_load_ctrl),
    .stall          (stall),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .err_misaligned (err_misaligned),
    .err_timeout    (err_timeout),
    .bus_valid      (bus_valid),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_be         (bus_be),
    .bus_ready      (bus_ready),
    .bus_rdata      (bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  // Reference: extract the addressed lane with shifts/masks and extend it.
  function automatic logic [31:0] model_load(logic [31:0] w, logic [31:0] addr, logic [2:0] lc);
    longint v;
    case (lc)
      3'b000, 3'b011: begin
        v = (longint'(w) >> (8 * (addr % 4))) & 255;
        if (lc == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b100: begin
        v = (longint'(w) >> (16 * ((addr % 4) / 2))) & 65535;
        if (lc == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  function automatic bit model_mis(logic [2:0] lc, logic [31:0] addr);
    if (lc == 3'b001 || lc == 3'b100) return (addr % 2) != 0;
    if (lc == 3'b010) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  // Drives one request and observes it until the core is released.
  // waits = number of BUS cycles without ready before ready is given.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input logic [2:0] lc, input int waits,
                         input logic [31:0] rdata,
                         output int n_stall, output int n_bv, output int n_lv,
                         output logic [31:0] ld, output int n_to, output int n_mis,
                         output int n_unstable, output logic [31:0] b_addr,
                         output logic [31:0] b_wdata, output logic [3:0] b_be,
                         output logic b_we);
    int  cyc, bus_cyc;
    bit  done;
    n_stall = 0; n_bv = 0; n_lv = 0; ld = 32'h0; n_to = 0; n_mis = 0; n_unstable = 0;
    b_addr = 32'h0; b_wdata = 32'h0; b_be = 4'h0; b_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_mask = mask; req_load_ctrl = lc;
    done = 1'b0; cyc = 0; bus_cyc = 0;
    while (!done && cyc < 64) begin
      bus_ready = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      #1;
      if (bus_valid) begin
        if (n_bv == 0) begin
          b_addr = bus_addr; b_wdata = bus_wdata; b_be = bus_be; b_we = bus_we;
        end else if (bus_addr !== b_addr || bus_wdata !== b_wdata ||
                     bus_be !== b_be || bus_we !== b_we) begin
          n_unstable++;
        end
        n_bv++;
        bus_ready = 1'b0;
        if (bus_cyc == waits) begin
          bus_ready = 1'b1;
          bus_rdata = rdata;
        end
        bus_cyc++;
      end
      if (stall) n_stall++;
      if (load_valid) begin n_lv++; ld = load_data; end
      if (err_timeout) n_to++;
      if (err_misaligned) n_mis++;
      if (cyc > 0 && !stall) done = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      bus_ready = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_mask = 4'h0; req_load_ctrl = 3'b000;
    bus_ready = 1'b0; bus_rdata = 32'h0;
    @(negedge clk); @(negedge clk);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_cmp++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL rst_bus_valid: got %b want 0", bus_valid); end
    n_cmp++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== 69'h0) begin
      n_fail++; $display("FAIL rst_bus_fields: got we=%b be=%h addr=%h wdata=%h want 0", bus_we, bus_be, bus_addr, bus_wdata);
    end
    n_cmp++; if ({load_valid, err_misaligned, err_timeout} !== 3'b000) begin
      n_fail++; $display("FAIL rst_pulses: got %b want 000", {load_valid, err_misaligned, err_timeout});
    end
    n_cmp++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL rst_load_data: got %h want 0", load_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_lb_sign();
    int s, bv, lv, t, m, u; logic [31:0] ld, ba, bw; logic [3:0] be; logic bwe;
    run_txn(1'b0, 32'h1003, 32'h0, 4'h0, 3'b000, 2, 32'h80FF_0000, s, bv, lv, ld, t, m, u, ba, bw, be, bwe);
    n_cmp++; if (ld !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", ld); end
    n_cmp++; if (lv !== 1) begin n_fail++; $display("FAIL lb_valid: got %0d want 1", lv); end
    n_cmp++; if (s !== 4) begin n_fail++; $display("FAIL lb_stall: got %0d want 4", s); end
  endtask

  task automatic test_lhu_zero();
    int s, bv, lv, t, m, u; logic [31:0] ld, ba, bw; logic [3:0] be; logic bwe;
    run_txn(1'b0, 32'h2002, 32'h0, 4'h0, 3'b100, 0, 32'hBEEF_1234, s, bv, lv, ld, t, m, u, ba, bw, be, bwe);
    n_cmp++; if (ld !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu_data: got %h want 0000beef", ld); end
    n_cmp++; if (ba !== 32'h2000) begin n_fail++; $display("FAIL lhu_addr: got %h want 00002000", ba); end
    n_cmp++; if (be !== 4'b0000) begin n_fail++; $display("FAIL lhu_be: got %b want 0000", be); end
    n_cmp++; if (s !== 2) begin n_fail++; $display("FAIL lhu_stall: got %0d want 2", s); end
  endtask

  task automatic test_sb_lanes();
    int s, bv, lv, t, m, u; logic [31:0] ld, ba, bw; logic [3:0] be; logic bwe;
    run_txn(1'b1, 32'h3001, 32'h0000_AB00, 4'b0010, 3'b000, 3, 32'h0, s, bv, lv, ld, t, m, u, ba, bw, be, bwe);
    n_cmp++; if (bwe !== 1'b1) begin n_fail++; $display("FAIL sb_we: got %b want 1", bwe); end
    n_cmp++; if (be !== 4'b0010) begin n_fail++; $display("FAIL sb_be: got %b want 0010", be); end
    n_cmp++; if (bw !== 32'h0000_AB00) begin n_fail++; $display("FAIL sb_wdata: got %h want 0000ab00", bw); end
    n_cmp++; if (u !== 0) begin n_fail++; $display("FAIL sb_stable: got %0d changes want 0", u); end
    n_cmp++; if (bv !== 4) begin n_fail++; $display("FAIL sb_bus_cycles: got %0d want 4", bv); end
    n_cmp++; if (lv !== 0) begin n_fail++; $display("FAIL sb_load_valid: got %0d want 0", lv); end
  endtask

  task automatic test_misaligned();
    int s, bv, lv, t, m, u; logic [31:0] ld, ba, bw; logic [3:0] be; logic bwe;
    logic [31:0] addrs [2] = '{32'h4002, 32'h4001};
    logic [2:0]  lcs   [2] = '{3'b010, 3'b001};
    for (int i = 0; i < 2; i++) begin
      run_txn(i[0], addrs[i], 32'h1234_5678, 4'hF, lcs[i], 0, 32'h0, s, bv, lv, ld, t, m, u, ba, bw, be, bwe);
      n_cmp++; if (m !== 1) begin n_fail++; $display("FAIL mis_pulse[%0d]: got %0d want 1", i, m); end
      n_cmp++; if (bv !== 0) begin n_fail++; $display("FAIL mis_bus[%0d]: got %0d want 0", i, bv); end
      n_cmp++; if (s !== 0) begin n_fail++; $display("FAIL mis_stall[%0d]: got %0d want 0", i, s); end
    end
  endtask

  task automatic test_timeout();
    int s, bv, lv, t, m, u; logic [31:0] ld, ba, bw; logic [3:0] be; logic bwe;
    run_txn(1'b0, 32'h5004, 32'h0, 4'h0, 3'b010, 1000, 32'hDEAD_BEEF, s, bv, lv, ld, t, m, u, ba, bw, be, bwe);
    n_cmp++; if (bv !== TO) begin n_fail++; $display("FAIL to_bus_cycles: got %0d want %0d", bv, TO); end
    n_cmp++; if (t !== 1) begin n_fail++; $display("FAIL to_pulse: got %0d want 1", t); end
    n_cmp++; if (ld !== 32'h0) begin n_fail++; $display("FAIL to_data: got %h want 0", ld); end
    n_cmp++; if (s !== TO + 1) begin n_fail++; $display("FAIL to_stall: got %0d want %0d", s, TO + 1); end
  endtask

  task automatic test_reset_mid_bus();
    int s, bv, lv, t, m, u; logic [31:0] ld, ba, bw; logic [3:0] be; logic bwe;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_load_ctrl = 3'b010;
    bus_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_cmp++; if (bus_valid !== 1'b1) begin n_fail++; $display("FAIL rmb_in_bus: got %b want 1", bus_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL rmb_dropped: got %b want 0", bus_valid); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmb_stall: got %b want 0", stall); end
    rst_n = 1'b1;
    run_txn(1'b0, 32'h8, 32'h0, 4'h0, 3'b010, 1, 32'hCAFE_F00D, s, bv, lv, ld, t, m, u, ba, bw, be, bwe);
    n_cmp++; if (ld !== 32'hCAFE_F00D || lv !== 1) begin
      n_fail++; $display("FAIL rmb_after: got %h lv=%0d want cafef00d lv=1", ld, lv);
    end
  endtask

  task automatic test_undef_ctrl();
    int s, bv, lv, t, m, u; logic [31:0] ld, ba, bw; logic [3:0] be; logic bwe;
    logic [31:0] rd;
    for (int c = 5; c < 8; c++) begin
      rd = $urandom;
      run_txn(1'b0, 32'h600 + 32'(4 * c), 32'h0, 4'h0, 3'(c), 0, rd, s, bv, lv, ld, t, m, u, ba, bw, be, bwe);
      n_cmp++; if (ld !== rd) begin n_fail++; $display("FAIL undef_ctrl[%0d]: got %h want %h", c, ld, rd); end
    end
  endtask

  task automatic test_random();
    int s, bv, lv, t, m, u; logic [31:0] ld, ba, bw; logic [3:0] be; logic bwe;
    logic we; logic [2:0] lc; logic [31:0] addr, wdata, rdata; logic [3:0] mask;
    int waits, exp_stall, exp_bv, bytes; bit mis, tmo;
    for (int i = 0; i < 60; i++) begin
      we    = 1'($urandom_range(0, 1));
      lc    = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
      addr  = $urandom;
      bytes = (lc == 3'b010) ? 4 : ((lc == 3'b001 || lc == 3'b100) ? 2 : 1);
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % bytes);
      wdata = $urandom; mask = 4'($urandom); rdata = $urandom;
      waits = $urandom_range(0, 5);
      run_txn(we, addr, wdata, mask, lc, waits, rdata, s, bv, lv, ld, t, m, u, ba, bw, be, bwe);
      mis       = model_mis(lc, addr);
      tmo       = !mis && waits >= TO;
      exp_stall = mis ? 0 : (tmo ? TO + 1 : waits + 2);
      exp_bv    = mis ? 0 : (tmo ? TO : waits + 1);
      n_cmp++; if (s !== exp_stall) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, s, exp_stall); end
      n_cmp++; if (bv !== exp_bv) begin n_fail++; $display("FAIL rnd_bus_cycles[%0d]: got %0d want %0d", i, bv, exp_bv); end
      n_cmp++; if (m !== int'(mis)) begin n_fail++; $display("FAIL rnd_mis[%0d]: got %0d want %0d", i, m, mis); end
      n_cmp++; if (t !== int'(tmo)) begin n_fail++; $display("FAIL rnd_timeout[%0d]: got %0d want %0d", i, t, tmo); end
      n_cmp++; if (lv !== int'(!mis && !we)) begin n_fail++; $display("FAIL rnd_lv[%0d]: got %0d want %0d", i, lv, !mis && !we); end
      n_cmp++; if (u !== 0) begin n_fail++; $display("FAIL rnd_stable[%0d]: got %0d want 0", i, u); end
      if (!mis && !we) begin
        n_cmp++;
        if (ld !== (tmo ? 32'h0 : model_load(rdata, addr, lc))) begin
          n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", i, ld, tmo ? 32'h0 : model_load(rdata, addr, lc));
        end
      end
      if (!mis) begin
        n_cmp++;
        if (ba !== {addr[31:2], 2'b00} || bwe !== we || be !== (we ? mask : 4'h0)) begin
          n_fail++; $display("FAIL rnd_bus[%0d]: got addr=%h we=%b be=%b want addr=%h we=%b be=%b",
                             i, ba, bwe, be, {addr[31:2], 2'b00}, we, we ? mask : 4'h0);
        end
        if (we) begin
          n_cmp++;
          if (bw !== wdata) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, bw, wdata); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb_sign();
    test_lhu_zero();
    test_sb_lanes();
    test_misaligned();
    test_timeout();
    test_reset_mid_bus();
    test_undef_ctrl();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bus_adapter.md
# lsu_bus_adapter

Multi-cycle data-memory bus adapter between the load/store controller and an external word-addressed data memory with a valid/ready handshake. It accepts one load or store per instruction and holds the core with `stall` until the bus completes. For loads, it right-aligns and sign/zero-extends the returned word per `load_ctrl`. Misaligned accesses and bus timeouts are flagged without corrupting memory.

## Interface
Parameters:
- `TIMEOUT`, 16: max cycles in BUS before abort; legal range 1..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: core has a load/store this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: lane-positioned store data (`wdata_mem`).
- `req_mask` in 4: byte enables for stores.
- `req_load_ctrl` in 3: 000 b, 001 h, 010 w, 011 bu, 100 hu; also encodes store width (000/001/010).
- `stall` out 1: hold PC and pipeline.
- `load_data` out 32: extended load result, valid with `load_valid`.
- `load_valid` out 1: one-cycle pulse.
- `err_misaligned` out 1: one-cycle pulse.
- `err_timeout` out 1: one-cycle pulse.
- `bus_valid` out 1: request to memory.
- `bus_we` out 1: write request.
- `bus_addr` out 32: `{addr[31:2],2'b00}`.
- `bus_wdata` out 32: store data.
- `bus_be` out 4: byte enables; 4'b0000 on reads.
- `bus_ready` in 1: completes the transfer this cycle.
- `bus_rdata` in 32: read word, valid when `bus_valid & bus_ready & ~bus_we`.

## Operation
- FSM states: IDLE, BUS, DONE.
- **Misaligned check** (combinational, IDLE only):
  - width h (001/100) with `addr[0]=1` is misaligned.
  - width w (010) with `addr[1:0]≠0` is misaligned.
- **IDLE:**
  - `req_valid` & aligned: register we/addr/wdata/mask/load_ctrl, clear counter, go to BUS.
  - `req_valid` & misaligned: pulse `err_misaligned` combinationally, no bus activity, no stall, stay in IDLE.
- **BUS:**
  - `bus_valid=1`; `bus_*` driven from the registered request.
  - On `bus_ready`: for loads, register the aligned/extended `bus_rdata` into `load_data`. Go to DONE.
  - Else counter++. If counter reaches `TIMEOUT-1` without ready: set the timeout flag, force `load_data=0`, go to DONE.
- **DONE:** `stall=0`; `load_valid=1` if the request was a load; `err_timeout=1` if flagged. Go to IDLE unconditionally; the core advances this cycle.
- **Load extraction:**
  - Byte lane = `addr[1:0]`, halfword lane = `addr[1]`.
  - b/h sign-extend; bu/hu zero-extend; w passes through.
  - Undefined `load_ctrl` (101–111) behaves as w.
- Stores never produce `load_valid`.

## Timing
- `stall = (IDLE & req_valid & aligned) | BUS`, combinational, so the request cycle itself is stalled.
- Minimum latency, ready in the first BUS cycle: request cycle (IDLE) → BUS → DONE. Three cycles total, two stalled.
- `bus_valid` stays asserted, with `bus_addr`/`bus_wdata`/`bus_be`/`bus_we` stable, until `bus_ready` or timeout. It is never withdrawn early except by reset.
- A request present in the DONE cycle is ignored; only IDLE accepts. Back-to-back instructions therefore see one IDLE cycle between accesses.
- Timeout: with no ready, BUS lasts exactly `TIMEOUT` cycles.
- **Reset:**
  - `rst_n=0` sampled at a clock edge forces IDLE and clears the registered request, counter, flags and `load_data`.
  - After that edge, every output is 0 (`stall` follows `req_valid` per the IDLE rule).
  - Reset mid-BUS drops `bus_valid` at that edge. An in-flight write is not retried.
- `bus_ready` while `bus_valid=0` is ignored.

## Structure
- Package `lsu_pkg`:
  - `load_ctrl_e` enum (LC_B, LC_H, LC_W, LC_BU, LC_HU).
  - `lsu_state_e` (IDLE, BUS, DONE).
  - Width helper function `is_misaligned(load_ctrl, addr[1:0])`.
- Sub-module `load_aligner`: combinational; inputs `rdata[31:0]`, `offset[1:0]`, `load_ctrl[2:0]`; output `data[31:0]`. Shared with any future cache path.
- Top: FSM, request register, timeout counter (`$clog2(TIMEOUT+1)` bits).

## Test plan
- **lb sign-extend:** lb at 0x1003, bus returns 0x80FF_0000 after 2 wait cycles → `load_data=0xFFFF_FF80`, `load_valid` pulse; `stall` high for 4 cycles.
- **lhu zero-extend:** lhu at 0x2002, rdata 0xBEEF_1234, ready immediately → `load_data=0x0000_BEEF`; `bus_addr=0x2000`; `bus_be=0000`.
- **sb lanes:** sb at 0x3001 with wdata 0x0000_AB00, mask 0010 → `bus_we=1`, `bus_be=0010`, `bus_wdata` held until ready; no `load_valid`.
- **Misaligned:** lw at 0x4002 → `err_misaligned` pulse, `bus_valid` never asserted, `stall=0`; sh at 0x4001 gives the same result.
- **Timeout:** `TIMEOUT=4`, lw with `bus_ready` held low → `bus_valid` high exactly 4 cycles, then `err_timeout` pulse with `load_data=0`, then IDLE.
- **Reset mid-BUS:** lw waiting 1 cycle, `rst_n=0` for one edge → next cycle `bus_valid=0`, IDLE. A later lw at 0x8 completes normally.
